// File: rtl/cvxif_pkg.sv
// cvxif_pkg: shared state, ID and payload types for the CV-X-IF offload controller
package cvxif_pkg;
  localparam int unsigned CVXIF_XLEN = 32;
  localparam int unsigned CVXIF_NUM_RS = 2;
  localparam int unsigned CVXIF_ID_WIDTH = 3;
  typedef enum logic [2:0] {IDLE, ISSUE, REG, COMMIT, RESULT, WB} state_e;
  typedef logic [CVXIF_ID_WIDTH-1:0] id_t;
  typedef struct packed {
    logic [31:0] instr;
    id_t         id;
  } issue_t;
  typedef struct packed {
    logic [CVXIF_NUM_RS*CVXIF_XLEN-1:0] rs;
    id_t                                id;
  } register_t;
  typedef struct packed {
    id_t  id;
    logic kill;
  } commit_t;
  typedef struct packed {
    id_t                   id;
    logic [4:0]            rd;
    logic [CVXIF_XLEN-1:0] data;
    logic                  we;
  } result_t;
endpackage

// File: rtl/cvxif_id_tracker.sv
// cvxif_id_tracker: wrapping transaction ID counter plus result-wait timeout counter
module cvxif_id_tracker #(
  parameter int unsigned ID_WIDTH = 3,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_i,
  input  logic                run_i,
  output logic [ID_WIDTH-1:0] id_o,
  output logic                expired_o
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [ID_WIDTH-1:0] id_q;
  logic [CW-1:0]       cnt_q;
  // ID advances once per retired transaction; wait counter runs only while waiting for a result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (inc_i) id_q <= id_q + 1'b1;
      cnt_q <= run_i ? cnt_q + 1'b1 : '0;
    end
  end
  assign id_o      = id_q;
  assign expired_o = run_i && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/cvxif_offload_ctrl.sv
// cvxif_offload_ctrl: single-outstanding CV-X-IF offload sequencer between core and coprocessor
module cvxif_offload_ctrl import cvxif_pkg::*; #(
  parameter int unsigned XLEN     = CVXIF_XLEN,
  parameter int unsigned NUM_RS   = CVXIF_NUM_RS,
  parameter int unsigned ID_WIDTH = CVXIF_ID_WIDTH,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   instr_valid_i,
  output logic                   instr_ready_o,
  input  logic [31:0]            instr_i,
  input  logic [NUM_RS*XLEN-1:0] rs_i,
  output logic                   x_issue_valid_o,
  input  logic                   x_issue_ready_i,
  output logic [31:0]            x_issue_instr_o,
  output logic [ID_WIDTH-1:0]    x_issue_id_o,
  input  logic                   x_issue_accept_i,
  input  logic                   x_issue_writeback_i,
  output logic                   x_register_valid_o,
  input  logic                   x_register_ready_i,
  output logic [NUM_RS*XLEN-1:0] x_register_rs_o,
  output logic [ID_WIDTH-1:0]    x_register_id_o,
  output logic                   x_commit_valid_o,
  output logic [ID_WIDTH-1:0]    x_commit_id_o,
  output logic                   x_commit_kill_o,
  input  logic                   x_result_valid_i,
  output logic                   x_result_ready_o,
  input  logic [ID_WIDTH-1:0]    x_result_id_i,
  input  logic [4:0]             x_result_rd_i,
  input  logic [XLEN-1:0]        x_result_data_i,
  input  logic                   x_result_we_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [4:0]             wb_rd_o,
  output logic [XLEN-1:0]        wb_data_o,
  output logic                   illegal_o,
  output logic                   timeout_o,
  output logic                   busy_o
);
  state_e                 state_q, state_d;
  logic [31:0]            instr_q;
  logic [NUM_RS*XLEN-1:0] rs_q;
  logic                   wb_flag_q;
  logic [4:0]             rd_q;
  logic [XLEN-1:0]        data_q;
  logic [ID_WIDTH-1:0]    id;
  logic                   id_inc, expired, res_match;
  assign res_match = x_result_valid_i && (x_result_id_i == id);
  cvxif_id_tracker #(.ID_WIDTH(ID_WIDTH), .TIMEOUT(TIMEOUT)) u_tracker (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .inc_i     (id_inc),
    .run_i     (state_q == RESULT),
    .id_o      (id),
    .expired_o (expired)
  );
  // Next state plus the error pulses and ID advance, all decided on the handshake cycle
  always_comb begin
    state_d   = state_q;
    id_inc    = 1'b0;
    illegal_o = 1'b0;
    timeout_o = 1'b0;
    case (state_q)
      IDLE:   if (instr_valid_i) state_d = ISSUE;
      ISSUE:  if (x_issue_ready_i) begin
        state_d   = x_issue_accept_i ? REG : IDLE;
        illegal_o = !x_issue_accept_i;
        id_inc    = !x_issue_accept_i;
      end
      REG:    if (x_register_ready_i) state_d = COMMIT;
      COMMIT: begin
        state_d = wb_flag_q ? RESULT : IDLE;
        id_inc  = !wb_flag_q;
      end
      RESULT: if (res_match) begin
        state_d = x_result_we_i ? WB : IDLE;
        id_inc  = !x_result_we_i;
      end else if (expired) begin
        state_d   = IDLE;
        timeout_o = 1'b1;
        id_inc    = 1'b1;
      end
      WB:     if (wb_ready_i) begin
        state_d = IDLE;
        id_inc  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // State register and payload holding registers; each captured only at its own handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      rs_q      <= '0;
      wb_flag_q <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && instr_valid_i) begin
        instr_q <= instr_i;
        rs_q    <= rs_i;
      end
      if (state_q == ISSUE && x_issue_ready_i) wb_flag_q <= x_issue_writeback_i;
      if (state_q == RESULT && res_match && x_result_we_i) begin
        rd_q   <= x_result_rd_i;
        data_q <= x_result_data_i;
      end
    end
  end
  assign instr_ready_o      = state_q == IDLE;
  assign busy_o             = state_q != IDLE;
  assign x_issue_valid_o    = state_q == ISSUE;
  assign x_issue_instr_o    = instr_q;
  assign x_issue_id_o       = id;
  assign x_register_valid_o = state_q == REG;
  assign x_register_rs_o    = rs_q;
  assign x_register_id_o    = id;
  assign x_commit_valid_o   = state_q == COMMIT;
  assign x_commit_id_o      = id;
  assign x_commit_kill_o    = 1'b0;
  assign x_result_ready_o   = state_q == RESULT;
  assign wb_valid_o         = state_q == WB;
  assign wb_rd_o            = rd_q;
  assign wb_data_o          = data_q;
endmodule

// File: tb/tb_cvxif_offload_ctrl.sv
// tb_cvxif_offload_ctrl: directed self-checking bench for the CV-X-IF offload controller
module tb_cvxif_offload_ctrl;
  localparam int TO = 255;
  logic        clk = 1'b0, rst_ni = 1'b0;
  logic        instr_valid_i = 1'b0, instr_ready_o;
  logic [31:0] instr_i = '0;
  logic [63:0] rs_i = '0;
  logic        x_issue_valid_o, x_issue_ready_i = 1'b0;
  logic [31:0] x_issue_instr_o;
  logic [2:0]  x_issue_id_o;
  logic        x_issue_accept_i = 1'b0, x_issue_writeback_i = 1'b0;
  logic        x_register_valid_o, x_register_ready_i = 1'b0;
  logic [63:0] x_register_rs_o;
  logic [2:0]  x_register_id_o;
  logic        x_commit_valid_o, x_commit_kill_o;
  logic [2:0]  x_commit_id_o;
  logic        x_result_valid_i = 1'b0, x_result_ready_o;
  logic [2:0]  x_result_id_i = '0;
  logic [4:0]  x_result_rd_i = '0;
  logic [31:0] x_result_data_i = '0;
  logic        x_result_we_i = 1'b0;
  logic        wb_valid_o, wb_ready_i = 1'b0;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        illegal_o, timeout_o, busy_o;
  logic [2:0]  exp_id = '0;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  cvxif_offload_ctrl #(.XLEN(32), .NUM_RS(2), .ID_WIDTH(3), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i), .rs_i(rs_i),
    .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
    .x_issue_instr_o(x_issue_instr_o), .x_issue_id_o(x_issue_id_o),
    .x_issue_accept_i(x_issue_accept_i), .x_issue_writeback_i(x_issue_writeback_i),
    .x_register_valid_o(x_register_valid_o), .x_register_ready_i(x_register_ready_i),
    .x_register_rs_o(x_register_rs_o), .x_register_id_o(x_register_id_o),
    .x_commit_valid_o(x_commit_valid_o), .x_commit_id_o(x_commit_id_o), .x_commit_kill_o(x_commit_kill_o),
    .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
    .x_result_id_i(x_result_id_i), .x_result_rd_i(x_result_rd_i),
    .x_result_data_i(x_result_data_i), .x_result_we_i(x_result_we_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .illegal_o(illegal_o), .timeout_o(timeout_o), .busy_o(busy_o)
  );

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy_o); end
    checks++; if (instr_ready_o !== 1'b1) begin failures++; $display("FAIL reset_instr_ready got=%0h exp=1", instr_ready_o); end
    checks++; if ({x_issue_valid_o, x_register_valid_o, x_commit_valid_o, x_result_ready_o, wb_valid_o, illegal_o, timeout_o} !== 7'b0) begin
      failures++; $display("FAIL reset_valids got=%0b exp=0", {x_issue_valid_o, x_register_valid_o, x_commit_valid_o, x_result_ready_o, wb_valid_o, illegal_o, timeout_o});
    end
    checks++; if (x_issue_id_o !== 3'd0) begin failures++; $display("FAIL reset_id got=%0h exp=0", x_issue_id_o); end
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // mode 0: plain result, 1: mismatched-ID result first, 2: no result (timeout)
  task automatic test_txn(input logic [31:0] ins, input logic [63:0] r, input logic acc, input logic wbf,
                          input logic we, input logic [4:0] rd, input logic [31:0] d, input int mode);
    int k;
    @(negedge clk);
    instr_valid_i = 1'b1; instr_i = ins; rs_i = r;
    x_issue_ready_i = 1'b1; x_issue_accept_i = acc; x_issue_writeback_i = wbf;
    x_register_ready_i = 1'b1; wb_ready_i = 1'b1;
    #1;
    checks++; if (instr_ready_o !== 1'b1) begin failures++; $display("FAIL idle_ready got=%0h exp=1", instr_ready_o); end
    @(negedge clk);
    instr_valid_i = 1'b0; instr_i = '0; rs_i = '0;
    #1;
    checks++; if (x_issue_valid_o !== 1'b1) begin failures++; $display("FAIL issue_valid got=%0h exp=1", x_issue_valid_o); end
    checks++; if (x_issue_instr_o !== ins) begin failures++; $display("FAIL issue_instr got=%0h exp=%0h", x_issue_instr_o, ins); end
    checks++; if (x_issue_id_o !== exp_id) begin failures++; $display("FAIL issue_id got=%0h exp=%0h", x_issue_id_o, exp_id); end
    checks++; if (illegal_o !== !acc) begin failures++; $display("FAIL illegal_pulse got=%0h exp=%0h", illegal_o, !acc); end
    if (!acc) begin
      @(negedge clk); #1;
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL illegal_busy got=%0h exp=0", busy_o); end
      checks++; if (illegal_o !== 1'b0) begin failures++; $display("FAIL illegal_once got=%0h exp=0", illegal_o); end
      checks++; if ({x_register_valid_o, x_commit_valid_o} !== 2'b00) begin failures++; $display("FAIL illegal_no_reg got=%0b exp=0", {x_register_valid_o, x_commit_valid_o}); end
      exp_id++;
      return;
    end
    @(negedge clk); #1;
    checks++; if (x_register_valid_o !== 1'b1) begin failures++; $display("FAIL reg_valid got=%0h exp=1", x_register_valid_o); end
    checks++; if (x_register_rs_o !== r) begin failures++; $display("FAIL reg_rs got=%0h exp=%0h", x_register_rs_o, r); end
    checks++; if (x_register_id_o !== exp_id) begin failures++; $display("FAIL reg_id got=%0h exp=%0h", x_register_id_o, exp_id); end
    @(negedge clk); #1;
    checks++; if ({x_commit_valid_o, x_commit_kill_o} !== 2'b10) begin failures++; $display("FAIL commit got=%0b exp=10", {x_commit_valid_o, x_commit_kill_o}); end
    checks++; if (x_commit_id_o !== exp_id) begin failures++; $display("FAIL commit_id got=%0h exp=%0h", x_commit_id_o, exp_id); end
    @(negedge clk); #1;
    checks++; if (x_commit_valid_o !== 1'b0) begin failures++; $display("FAIL commit_once got=%0h exp=0", x_commit_valid_o); end
    if (!wbf) begin
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL nowb_idle got=%0h exp=0", busy_o); end
      exp_id++;
      return;
    end
    checks++; if (x_result_ready_o !== 1'b1) begin failures++; $display("FAIL result_ready got=%0h exp=1", x_result_ready_o); end
    if (mode == 2) begin
      k = 1;
      while (!timeout_o && k < TO + 4) begin @(negedge clk); #1; k++; end
      checks++; if (k !== TO) begin failures++; $display("FAIL timeout_cycle got=%0d exp=%0d", k, TO); end
      @(negedge clk); #1;
      checks++; if ({busy_o, timeout_o} !== 2'b00) begin failures++; $display("FAIL timeout_idle got=%0b exp=00", {busy_o, timeout_o}); end
      exp_id++;
      return;
    end
    if (mode == 1) begin
      x_result_valid_i = 1'b1; x_result_id_i = exp_id + 3'd5; x_result_we_i = 1'b1; x_result_rd_i = 5'd9; x_result_data_i = 32'd99;
      @(negedge clk); #1;
      checks++; if ({x_result_ready_o, wb_valid_o} !== 2'b10) begin failures++; $display("FAIL drop_mismatch got=%0b exp=10", {x_result_ready_o, wb_valid_o}); end
    end
    x_result_valid_i = 1'b1; x_result_id_i = exp_id; x_result_we_i = we; x_result_rd_i = rd; x_result_data_i = d;
    @(negedge clk);
    x_result_valid_i = 1'b0;
    #1;
    if (!we) begin
      checks++; if ({busy_o, wb_valid_o} !== 2'b00) begin failures++; $display("FAIL nowe_idle got=%0b exp=00", {busy_o, wb_valid_o}); end
      exp_id++;
      return;
    end
    checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL wb_valid got=%0h exp=1", wb_valid_o); end
    checks++; if (wb_rd_o !== rd) begin failures++; $display("FAIL wb_rd got=%0h exp=%0h", wb_rd_o, rd); end
    checks++; if (wb_data_o !== d) begin failures++; $display("FAIL wb_data got=%0h exp=%0h", wb_data_o, d); end
    @(negedge clk); #1;
    checks++; if ({busy_o, wb_valid_o} !== 2'b00) begin failures++; $display("FAIL wb_done got=%0b exp=00", {busy_o, wb_valid_o}); end
    exp_id++;
  endtask

  task automatic test_issue_stall;
    @(negedge clk);
    instr_valid_i = 1'b1; instr_i = 32'h1234_5677; rs_i = 64'h1;
    x_issue_ready_i = 1'b0; x_issue_accept_i = 1'b1; x_issue_writeback_i = 1'b0; x_register_ready_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      instr_valid_i = 1'b0; instr_i = i;
      #1;
      checks++; if ({x_issue_valid_o, x_register_valid_o} !== 2'b10) begin failures++; $display("FAIL stall_valid cyc=%0d got=%0b exp=10", i, {x_issue_valid_o, x_register_valid_o}); end
      checks++; if (x_issue_instr_o !== 32'h1234_5677 || x_issue_id_o !== exp_id) begin
        failures++; $display("FAIL stall_payload cyc=%0d got=%0h/%0h exp=12345677/%0h", i, x_issue_instr_o, x_issue_id_o, exp_id);
      end
    end
    x_issue_ready_i = 1'b1;
    @(negedge clk); #1;
    checks++; if (x_register_valid_o !== 1'b1) begin failures++; $display("FAIL stall_reg_entry got=%0h exp=1", x_register_valid_o); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL stall_idle got=%0h exp=0", busy_o); end
    exp_id++;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    instr_valid_i = 1'b1; instr_i = 32'h0000_002B; rs_i = {32'd1, 32'd2};
    x_issue_ready_i = 1'b1; x_issue_accept_i = 1'b1; x_issue_writeback_i = 1'b1; x_register_ready_i = 1'b1; wb_ready_i = 1'b1;
    @(negedge clk);
    instr_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (x_result_ready_o !== 1'b1) begin failures++; $display("FAIL mid_in_result got=%0h exp=1", x_result_ready_o); end
    x_result_valid_i = 1'b1; x_result_id_i = exp_id; x_result_we_i = 1'b1; x_result_rd_i = 5'd4; x_result_data_i = 32'd5;
    rst_ni = 1'b0;
    #1;
    checks++; if ({x_result_ready_o, wb_valid_o, x_commit_valid_o, busy_o} !== 4'b0) begin
      failures++; $display("FAIL mid_reset_outs got=%0b exp=0", {x_result_ready_o, wb_valid_o, x_commit_valid_o, busy_o});
    end
    checks++; if (x_issue_id_o !== 3'd0) begin failures++; $display("FAIL mid_reset_id got=%0h exp=0", x_issue_id_o); end
    @(negedge clk);
    rst_ni = 1'b1; x_result_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if ({wb_valid_o, x_commit_valid_o, x_commit_kill_o, busy_o} !== 4'b0) begin
        failures++; $display("FAIL mid_after cyc=%0d got=%0b exp=0", i, {wb_valid_o, x_commit_valid_o, x_commit_kill_o, busy_o});
      end
    end
    exp_id = '0;
  endtask

  initial begin
    test_reset;
    test_txn(32'h0000_002B, {32'd7, 32'd5}, 1'b1, 1'b1, 1'b1, 5'd3, 32'd12, 0);
    test_txn(32'h0000_102B, {32'd1, 32'd1}, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 0);
    test_issue_stall;
    test_txn(32'h0000_202B, {32'd8, 32'd9}, 1'b1, 1'b1, 1'b1, 5'd6, 32'hDEAD_BEEF, 1);
    test_txn(32'h0000_302B, {32'd2, 32'd3}, 1'b1, 1'b1, 1'b1, 5'd1, 32'd1, 2);
    test_txn(32'h0000_402B, {32'd4, 32'd4}, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 0);
    test_txn(32'h0000_502B, {32'd5, 32'd6}, 1'b1, 1'b1, 1'b0, 5'd2, 32'd0, 0);
    test_txn(32'h0000_602B, {32'd6, 32'd7}, 1'b1, 1'b1, 1'b1, 5'd0, 32'h0000_0ABC, 0);
    test_txn(32'h0000_702B, {32'd7, 32'd8}, 1'b1, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 0);
    test_reset_mid;
    test_txn(32'h0000_002B, {32'd3, 32'd4}, 1'b1, 1'b1, 1'b1, 5'd10, 32'd7, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
